// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Sequential shift-add multiplier that borrows the shared ALU as
//            its adder. Each granted RUN cycle issues an ADD and folds the
//            sum and carry into a double-width shift register. The product
//            becomes valid after WIDTH granted iterations.
// Options  : ALU_MUL_SIGNED_EN - adds the i_is_signed port and a one-cycle
//            SIGN state that applies the product sign (magnitude multiply).
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef ALU_MUL_SIGNED_EN
  input  logic             i_is_signed,
`endif
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic             o_alu_req,
  input  logic             i_alu_gnt,
  output logic             o_alu_oe,
  output logic [1:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_carry
);

  // ALU operation encoding shared with the ALU
  localparam logic [1:0] c_ALU_OP_PASS = 2'd0;
  localparam logic [1:0] c_ALU_OP_ADD  = 2'd1;

  // Iteration counter sized to hold 0 .. WIDTH-1
  localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef ALU_MUL_SIGNED_EN
    S_SIGN = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e             r_state;
  logic               r_ready;
  logic               r_done;
  logic               r_alu_req;
  logic [1:0]         r_alu_op;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;

  // Next {acc, mplier}: ALU sum with carry shifted right by one, the
  // multiplier LSB just consumed drops out of the bottom.
  logic [2*WIDTH-1:0] w_shift;
  assign w_shift = {i_alu_carry, i_alu_result, r_mplier[WIDTH-1:1]};

  // Operand values loaded on accept (magnitudes when signed mode is used)
  logic [WIDTH-1:0] w_load_a;
  logic [WIDTH-1:0] w_load_b;
`ifdef ALU_MUL_SIGNED_EN
  logic               r_neg;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod_neg;

  // Absolute values; the most-negative value wraps to itself, which is its
  // correct unsigned magnitude.
  assign w_load_a   = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_load_b   = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  // Two's complement negation of the full double-width magnitude product
  assign w_prod_raw = {r_acc, r_mplier};
  assign w_prod_neg = -w_prod_raw;
`else
  // Unsigned build: operands load unchanged
  assign w_load_a = i_a;
  assign w_load_b = i_b;
`endif

  // Sequencer: accept, iterate on granted cycles, finalize, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_alu_req <= 1'b0;
      r_alu_op  <= c_ALU_OP_PASS;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
`ifdef ALU_MUL_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mcand   <= w_load_a;
            r_mplier  <= w_load_b;
            r_acc     <= '0;
            r_cnt     <= '0;
`ifdef ALU_MUL_SIGNED_EN
            r_neg     <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
`endif
            r_state   <= S_RUN;
            r_ready   <= 1'b0;
            r_alu_req <= 1'b1;
            r_alu_op  <= c_ALU_OP_ADD;
          end
        end
        S_RUN: begin
          // A denied grant is a full stall: nothing below is touched
          if (i_alu_gnt) begin
            {r_acc, r_mplier} <= w_shift;
            r_cnt             <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_LAST) begin
              r_alu_req <= 1'b0;
              r_alu_op  <= c_ALU_OP_PASS;
`ifdef ALU_MUL_SIGNED_EN
              r_state   <= S_SIGN;
`else
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_prod_hi <= w_shift[2*WIDTH-1:WIDTH];
              r_prod_lo <= w_shift[WIDTH-1:0];
`endif
            end
          end
        end
`ifdef ALU_MUL_SIGNED_EN
        S_SIGN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          if (r_neg) begin
            {r_prod_hi, r_prod_lo} <= w_prod_neg;
          end else begin
            {r_prod_hi, r_prod_lo} <= w_prod_raw;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_ready   <= 1'b1;
          r_alu_req <= 1'b0;
          r_alu_op  <= c_ALU_OP_PASS;
        end
      endcase
    end
  end

  // Output enable follows the live grant so the bus is released at once on
  // a denied cycle or when reset clears r_alu_req.
  assign o_alu_oe  = r_alu_req & i_alu_gnt;

  // Registered status and product outputs
  assign o_ready   = r_ready;
  assign o_done    = r_done;
  assign o_alu_req = r_alu_req;
  assign o_alu_op  = r_alu_op;
  assign o_prod_hi = r_prod_hi;
  assign o_prod_lo = r_prod_lo;

  // ALU operands: accumulator plus multiplicand gated by the multiplier LSB
  assign o_alu_a   = r_acc;
  assign o_alu_b   = r_mplier[0] ? r_mcand : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Brief    : Self-checking bench for alu_mul_seq (WIDTH=32). Table-driven
//            multiply vectors plus hand-written stall, busy and reset
//            sequences. Signed vectors are included when ALU_MUL_SIGNED_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

  localparam int W = 32;
`ifdef ALU_MUL_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ALU_MUL_SIGNED_EN
  logic         is_signed;
`endif
  logic         gnt;
  logic         o_ready;
  logic         o_done;
  logic [W-1:0] o_prod_hi;
  logic [W-1:0] o_prod_lo;
  logic         o_alu_req;
  logic         o_alu_oe;
  logic [1:0]   o_alu_op;
  logic [W-1:0] o_alu_a;
  logic [W-1:0] o_alu_b;
  logic [W:0]   alu_sum;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_prev_hi = '0;
  logic [W-1:0] exp_prev_lo = '0;

  // Shared ALU model: plain 32-bit adder with carry out
  assign alu_sum = {1'b0, o_alu_a} + {1'b0, o_alu_b};

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_a          (a),
    .i_b          (b),
`ifdef ALU_MUL_SIGNED_EN
    .i_is_signed  (is_signed),
`endif
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_prod_hi    (o_prod_hi),
    .o_prod_lo    (o_prod_lo),
    .o_alu_req    (o_alu_req),
    .i_alu_gnt    (gnt),
    .o_alu_oe     (o_alu_oe),
    .o_alu_op     (o_alu_op),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .i_alu_result (alu_sum[W-1:0]),
    .i_alu_carry  (alu_sum[W])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sg;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic bit is_deny(input int k);
    return (k inside {2, 5, 6, 11, 18, 26, 31});
  endfunction

  // One complete multiply with latency, product, hold and bus checks
  task automatic do_mul(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vs, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int elat, input bit stall_en, input bit busy_en,
                        input bit dstart_en);
    int k;
    bit got;
    bit oe_ok;
    int lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    @(negedge clk);
    chk({nm, " ready_before"}, o_ready, 1);
    start = 1'b1;
    a = va;
    b = vb;
`ifdef ALU_MUL_SIGNED_EN
    is_signed = vs;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '0;
    b = '0;
    k = 1; got = 0; oe_ok = 1; lat = 0; hi = '0; lo = '0;
    while (k < 200 && !got) begin
      gnt = !(stall_en && is_deny(k));
      if (busy_en && k == 5) begin
        start = 1'b1; a = 32'd7; b = 32'd9;
      end else if (busy_en && k == 6) begin
        start = 1'b0; a = '0; b = '0;
      end
      @(negedge clk);
      if (!gnt && (o_alu_oe !== 1'b0 || o_alu_req !== 1'b1)) oe_ok = 0;
      if (k == 1) chk({nm, " run_oe_op"}, {o_alu_oe, o_alu_op}, {1'b1, OP_ADD});
      if (k == 2) chk({nm, " ready_low"}, o_ready, 0);
      if (k == 3) chk({nm, " prod_hold"}, {o_prod_hi, o_prod_lo}, {exp_prev_hi, exp_prev_lo});
      if (o_done === 1'b1) begin
        got = 1; lat = k; hi = o_prod_hi; lo = o_prod_lo;
        if (dstart_en) begin
          start = 1'b1; a = 32'd7; b = 32'd9;
        end
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " prod_hi"}, hi, ehi);
    chk({nm, " prod_lo"}, lo, elo);
    if (stall_en) chk({nm, " oe_denied"}, oe_ok, 1);
    @(posedge clk);
    #1;
    start = 1'b0; a = '0; b = '0; gnt = 1'b1;
    @(negedge clk);
    chk({nm, " after_done"}, {o_done, o_ready}, {1'b0, 1'b1});
    exp_prev_hi = ehi;
    exp_prev_lo = elo;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    gnt = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
    is_signed = 1'b0;
`endif

    vt.push_back('{32'd3,        32'd5,        1'b0, 32'd0,        32'd15});
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{32'd0,        32'hFFFFFFFF, 1'b0, 32'd0,        32'd0});
    vt.push_back('{32'h80000000, 32'd2,        1'b0, 32'd1,        32'd0});
    vt.push_back('{32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        32'hFFFFFFFF});
    vt.push_back('{32'h00010000, 32'h00010000, 1'b0, 32'd1,        32'd0});
`ifdef ALU_MUL_SIGNED_EN
    vt.push_back('{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vt.push_back('{32'hFFFFFFFD, 32'd5,        1'b0, 32'd4,        32'hFFFFFFF1});
    vt.push_back('{32'h80000000, 32'd1,        1'b1, 32'hFFFFFFFF, 32'h80000000});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready_done", {o_ready, o_done}, {1'b1, 1'b0});
    chk("reset req_oe_op", {o_alu_req, o_alu_oe, o_alu_op}, {1'b0, 1'b0, OP_PASS});
    chk("reset alu_ab", {o_alu_a, o_alu_b}, 64'd0);
    chk("reset prod", {o_prod_hi, o_prod_lo}, 64'd0);
    rst_n = 1'b1;

    // Reset during RUN cycle 10: outputs drop at once, no done afterwards
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0; a = '0; b = '0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst in_run", o_alu_req, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst ready_oe", {o_ready, o_alu_oe, o_alu_req}, {1'b1, 1'b0, 1'b0});
    chk("midrst prod", {o_prod_hi, o_prod_lo}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done !== 1'b0) seen = 1;
    end
    chk("midrst no_done", seen, 0);
    chk("midrst idle", o_ready, 1);

    // Table-driven vectors with continuous grant
    foreach (vt[i]) begin
      do_mul($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sg, vt[i].hi, vt[i].lo,
             LAT, 1'b0, 1'b0, 1'b0);
    end

    // Seven denied grants scattered through RUN
    do_mul("stall", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0B00EA4E, 32'h242D2080,
           LAT + 7, 1'b1, 1'b0, 1'b0);

    // Start pulsed mid-RUN and on the done cycle must both be ignored
    do_mul("busy", 32'd2, 32'd2, 1'b0, 32'd0, 32'd4, LAT, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("busy still_idle", {o_ready, o_alu_req}, {1'b1, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
